// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer: controller
// state encoding and the width of the reused arithmetic slice.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/subtract slice built from ripple full-adder cells.
// cin is a real input so consecutive nibbles can be chained through a register.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W:0]   carry;

    // Subtraction is A + ~B with the +1 arriving through cin on the first nibble.
    assign b_eff    = b ^ {NIBBLE_W{sub}};
    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign cout = carry[NIBBLE_W];
    assign c3   = carry[NIBBLE_W-1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-word adder/subtractor that reuses one 4-bit slice, LSB nibble first,
// with valid/ready handshakes on the request and result sides.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                      cout,
    output logic                      overflow,
    output logic                      busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t state;
    state_t state_next;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sub_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     result_q;
    logic             cout_q;
    logic             overflow_q;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_c3;
    logic                last_nibble;

    assign slice_a     = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign slice_b     = b_q[idx*NIBBLE_W +: NIBBLE_W];
    assign last_nibble = (idx == LAST_IDX);

    nibble_addsub u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .sub  (sub_q),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and nibble-serial datapath; reset clears the visible
    // outputs too so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx        <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    result_q[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last_nibble) begin
                        // Signed overflow: carry into the MSB differs from carry out.
                        cout_q     <= slice_cout;
                        overflow_q <= slice_c3 ^ slice_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (NIBBLES=4): directed corner cases,
// randomized operations against an arithmetic reference model, backpressure and reset.
module tb_addsub_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int passes = 0;

    addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, us, ss;
        logic [W-1:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            us = ux - uy;
            ss = sx - sy;
            c  = (ux >= uy);
        end else begin
            us = ux + uy;
            ss = sx + sy;
            c  = (us > 65535);
        end
        r = us[W-1:0];
        o = (ss > 32767) || (ss < -32768);
        return {c, o, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for out_valid; leaves the result held (out_ready=0).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic ts,
                         output logic [W-1:0] r, output logic c, output logic o,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        a        = ta;
        b        = tb_op;
        sub      = ts;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        r = result;
        c = cout;
        o = overflow;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (result !== '0) $display("FAIL reset_result got=%h exp=0000", result); else passes++;
        checks++; if ({cout, overflow} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {cout, overflow}); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h8000};
        logic [W-1:0] vb [5] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
        logic         vs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] er [5] = '{16'h2233, 16'hFFFE, 16'h8000, 16'h0000, 16'h7FFF};
        logic         ec [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] r;
        logic c, o;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], r, c, o, lat);
            checks++; if (lat !== NIB) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NIB); else passes++;
            checks++; if (r !== er[i]) $display("FAIL dir%0d_result got=%h exp=%h", i, r, er[i]); else passes++;
            checks++; if ({c, o} !== {ec[i], eo[i]}) $display("FAIL dir%0d_cout_ovf got=%b%b exp=%b%b", i, c, o, ec[i], eo[i]); else passes++;
            release_result();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tbv, r;
        logic ts, c, o;
        logic [W+1:0] exp;
        int lat, hold;
        for (int i = 0; i < 40; i++) begin
            ta  = W'($urandom);
            tbv = (i % 8 == 0) ? ta : W'($urandom);
            ts  = 1'($urandom);
            exp = model(ta, tbv, ts);
            do_op(ta, tbv, ts, r, c, o, lat);
            checks++; if (lat !== NIB) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NIB); else passes++;
            checks++; if ({c, o, r} !== exp) $display("FAIL rnd%0d a=%h b=%h sub=%b got=%b%b_%h exp=%b%b_%h",
                                                     i, ta, tbv, ts, c, o, r, exp[W+1], exp[W], exp[W-1:0]); else passes++;
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) tick();
            checks++; if ({out_valid, cout, overflow, result} !== {1'b1, exp}) $display("FAIL rnd%0d_hold got=%b_%h exp=1_%h", i, out_valid, result, exp[W-1:0]); else passes++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r;
        logic c, o;
        int lat;
        do_op(16'h1234, 16'h0FFF, 1'b0, r, c, o, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                a        = 16'hAAAA;
                b        = 16'h5555;
                sub      = 1'b1;
                in_valid = 1'b1;
            end
            checks++; if ({out_valid, in_ready, busy} !== 3'b101) $display("FAIL bp%0d_ctrl got=%b exp=101", k, {out_valid, in_ready, busy}); else passes++;
            checks++; if ({cout, overflow, result} !== {2'b00, 16'h2233}) $display("FAIL bp%0d_result got=%b%b_%h exp=00_2233", k, cout, overflow, result); else passes++;
            tick();
        end
        in_valid = 1'b0;
        release_result();
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_release got=%b exp=100", {in_ready, out_valid, busy}); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        int last_hs, handshakes;
        logic acc, hs;
        last_hs    = -1;
        handshakes = 0;
        a          = W'($urandom);
        b          = W'($urandom);
        sub        = 1'($urandom);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_ready && in_valid;
            hs  = out_valid && out_ready;
            if (acc) q.push_back(model(a, b, sub));
            if (hs) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                checks++; if ({cout, overflow, result} !== exp) $display("FAIL b2b_result got=%b%b_%h exp=%b%b_%h", cout, overflow, result, exp[W+1], exp[W], exp[W-1:0]); else passes++;
                if (last_hs >= 0) begin
                    checks++; if (cyc - last_hs !== NIB + 2) $display("FAIL b2b_interval got=%0d exp=%0d", cyc - last_hs, NIB + 2); else passes++;
                end
                last_hs = cyc;
                handshakes++;
            end
            tick();
            if (acc) begin
                a   = W'($urandom);
                b   = W'($urandom);
                sub = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++; if (handshakes < 8) $display("FAIL b2b_count got=%0d exp>=8", handshakes); else passes++;
        for (int k = 0; k < 8 && !in_ready; k++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] r;
        logic c, o;
        int lat, spurious;
        a        = 16'hFFFF;
        b        = 16'h0001;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL midrst_ctrl got=%b exp=100", {in_ready, out_valid, busy}); else passes++;
        checks++; if (result !== '0) $display("FAIL midrst_result got=%h exp=0000", result); else passes++;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) spurious++;
            tick();
        end
        checks++; if (spurious !== 0) $display("FAIL midrst_no_output got=%0d exp=0", spurious); else passes++;
        do_op(16'h0001, 16'h0001, 1'b0, r, c, o, lat);
        checks++; if (lat !== NIB) $display("FAIL midrst_latency got=%0d exp=%0d", lat, NIB); else passes++;
        checks++; if ({c, o, r} !== {2'b00, 16'h0002}) $display("FAIL midrst_result_after got=%b%b_%h exp=00_0002", c, o, r); else passes++;
        release_result();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
